// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, prediction response and execute training
// signals of the branch target buffer, grouped with fetch/execute (master) and predictor (slave) views.
interface branch_predictor_if;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        flush;
    logic        pred_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        up_valid;
    logic [31:0] up_pc;
    logic        up_uncond;
    logic        up_taken;
    logic [31:0] up_target;
    logic        up_pred_taken;
    logic [31:0] mis_count;

    modport master (
        output lk_valid, lk_pc, flush, up_valid, up_pc, up_uncond, up_taken, up_target, up_pred_taken,
        input  pred_valid, pred_hit, pred_taken, pred_target, mis_count
    );
    modport slave (
        input  lk_valid, lk_pc, flush, up_valid, up_pc, up_uncond, up_taken, up_target, up_pred_taken,
        output pred_valid, pred_hit, pred_taken, pred_target, mis_count
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters, 1-cycle lookup,
// trained by resolved branches from execute, with a saturating misprediction counter.
module branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bp
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int N        = 1 << INDEX_BITS;

    logic [N-1:0]          r_valid;
    logic [TAG_BITS-1:0]   r_tag    [N];
    logic [31:0]           r_target [N];
    logic [1:0]            r_ctr    [N];
    logic                  r_pred_valid;
    logic                  r_pred_hit;
    logic                  r_pred_taken;
    logic [31:0]           r_pred_target;
    logic [31:0]           r_mis_count;

    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0]   w_lk_tag;
    logic                  w_lk_hit;
    logic                  w_lk_taken;
    logic [31:0]           w_lk_target;
    logic                  w_lk_fire;
    logic [INDEX_BITS-1:0] w_up_idx;
    logic [TAG_BITS-1:0]   w_up_tag;
    logic                  w_up_hit;
    logic                  w_up_tk;
    logic [1:0]            w_up_cur;
    logic [1:0]            w_up_ctr;
    logic                  w_up_we;
    logic                  w_mis;

    always_comb begin
        w_lk_idx    = bp.lk_pc[INDEX_BITS+1:2];
        w_lk_tag    = bp.lk_pc[31:INDEX_BITS+2];
        w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
        w_lk_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
        w_lk_target = w_lk_taken ? r_target[w_lk_idx] : bp.lk_pc + 32'd4;
        w_lk_fire   = bp.lk_valid && !bp.flush;
        w_up_idx    = bp.up_pc[INDEX_BITS+1:2];
        w_up_tag    = bp.up_pc[31:INDEX_BITS+2];
        w_up_hit    = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
        w_up_tk     = bp.up_taken || bp.up_uncond;
        w_up_cur    = r_ctr[w_up_idx];
        // A miss only reaches the write path when taken, so it always allocates.
        w_up_ctr    = !w_up_hit     ? (bp.up_uncond ? 2'd3 : 2'd2) :
                      bp.up_uncond  ? 2'd3 :
                      w_up_tk       ? ((w_up_cur == 2'd3) ? 2'd3 : w_up_cur + 2'd1) :
                                      ((w_up_cur == 2'd0) ? 2'd0 : w_up_cur - 2'd1);
        w_up_we     = bp.up_valid && (w_up_hit || w_up_tk);
        w_mis       = bp.up_valid && (bp.up_taken != bp.up_pred_taken) && (r_mis_count != 32'hFFFF_FFFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < N; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_up_we) begin
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= w_up_tk ? bp.up_target : r_target[w_up_idx];
            r_ctr[w_up_idx]    <= w_up_ctr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_valid  <= 1'b0;
            r_pred_hit    <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            r_mis_count   <= '0;
        end else begin
            r_pred_valid <= w_lk_fire;
            if (w_lk_fire) begin
                r_pred_hit    <= w_lk_hit;
                r_pred_taken  <= w_lk_taken;
                r_pred_target <= w_lk_target;
            end
            if (w_mis)
                r_mis_count <= r_mis_count + 32'd1;
        end
    end

    assign bp.pred_valid  = r_pred_valid;
    assign bp.pred_hit    = r_pred_hit;
    assign bp.pred_taken  = r_pred_taken;
    assign bp.pred_target = r_pred_target;
    assign bp.mis_count   = r_mis_count;
endmodule
